tx_arbiter: RTL

//   Shares one UART transmit path (tx_ctl) between NREQ byte requesters.

---
 rtl/tx_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin arbiter sharing one UART transmit path between NREQ byte requesters
//
// Ports:
//   clk       in   1       system clock
//   rst       in   1       synchronous active-high reset, dominant
//   req       in   NREQ    req[i]=1: requester i presents a byte on its slice
//   req_data  in   8*NREQ  slice i = req_data[8*i+7:8*i]
//   req_last  in   NREQ    byte ends requester i's message (releases the lock)
//   ack       out  NREQ    one-cycle pulse: byte of requester i captured
//   gnt       out  NREQ    one-hot current owner, 0 when idle
//   out_data  out  8       byte to transmitter, held until the next issue
//   out_rdy   out  1       one-cycle strobe to the transmitter
//   tx_rdy    in   1       transmitter ready (1) / busy (0)
//   busy      out  1       arbiter not idle
//   to_err    out  1       sticky: transmitter never went busy after a strobe

module tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int BUSY_TO = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        out_data,
    output logic              out_rdy,
    input  logic              tx_rdy,
    output logic              busy,
    output logic              to_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic            lock;
    logic [CW-1:0]   cnt;

    logic [7:0]      slice [NREQ];
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign slice[g] = req_data[8*g +: 8];
    end

    // Round-robin search starting just after rr_ptr. Walking the offsets from
    // the far end down lets the nearest set request overwrite the others.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = PW'((int'(rr_ptr) + off) % NREQ);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // The strobe, ack and captured byte are registered on entry to ISSUE, so
    // the ISSUE cycle is exactly the cycle in which out_rdy/ack are high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ack      <= '0;
            out_rdy  <= 1'b0;
            out_data <= 8'h00;
            busy     <= 1'b0;
            to_err   <= 1'b0;
            rr_ptr   <= PW'(NREQ - 1);
            owner    <= '0;
            lock     <= 1'b0;
            cnt      <= '0;
        end else begin
            ack     <= '0;
            out_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_rdy && win_found) begin
                        gnt      <= NREQ'(1) << win_idx;
                        ack      <= NREQ'(1) << win_idx;
                        rr_ptr   <= win_idx;
                        owner    <= win_idx;
                        out_rdy  <= 1'b1;
                        out_data <= slice[win_idx];
                        lock     <= ~req_last[win_idx];
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Only a fall of tx_rdy moves on; a high level just waits.
                    if (!tx_rdy) begin
                        state <= WAIT_DONE;
                    end else begin
                        // cnt is one less than the cycles since the strobe, so
                        // the registered flag lands on the BUSY_TO-th cycle.
                        if (int'(cnt) + 2 >= BUSY_TO) begin
                            to_err <= 1'b1;
                            state  <= WAIT_DONE;
                        end
                        if (int'(cnt) < BUSY_TO) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (tx_rdy) begin
                        if (lock && req[owner]) begin
                            ack      <= gnt;
                            out_rdy  <= 1'b1;
                            out_data <= slice[owner];
                            lock     <= ~req_last[owner];
                            state    <= ISSUE;
                        end else begin
                            lock  <= 1'b0;
                            gnt   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
